mem_stall_ctrl: RTL and testbench

//  Producer of the pipeline-wide mem_stall freeze consumed by every pipeline register
//  (IF_ID, ID_EX, EX_MEM, MEM_WB hold their contents while it is high).

---
 rtl/mem_stall_ctrl_pkg.sv | 19 +
 rtl/mem_stall_ctrl_stall_timer.sv | 37 +++
 rtl/mem_stall_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_stall_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stall_ctrl_pkg.sv
// rtl/mem_stall_ctrl_pkg.sv - MEM-stage access controller state encodings and shared constants
package mem_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 64;
    localparam int unsigned TIMER_W         = 8;

    // Exactly one direction and a halfword-aligned address.
    function automatic logic req_ok(input logic rd, input logic wr, input logic a0);
        return (rd ^ wr) && !a0;
    endfunction

endpackage

// File: rtl/mem_stall_ctrl_stall_timer.sv
// rtl/mem_stall_ctrl_stall_timer.sv - 8-bit clear/enable counter with terminal-count flag
module mem_stall_ctrl_stall_timer
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned TC_VAL = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the TC_VAL-th enabled cycle after a clear.
    assign tc = en && (count_q == TIMER_W'(TC_VAL - 1));

endmodule

// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - MEM-stage load/store sequencer producing the pipeline-wide stall
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                err_q, err_d;
    logic                wr_q, wr_d;
    logic                ok_q, ok_d;
    logic                tmr_clr, tmr_en, tmr_tc;

    mem_stall_ctrl_stall_timer #(
        .TC_VAL (TIMEOUT_CYC)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .tc  (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        wr_d        = wr_q;
        ok_d        = ok_q;
        mem_stall   = 1'b0;
        mem_en      = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_ok(rd_req, wr_req, addr[0])) begin
                    mem_stall   = 1'b1;
                    mem_addr_d  = addr;
                    mem_wdata_d = wdata;
                    wr_d        = wr_req;
                    state_d     = S_REQ;
                end else if (rd_req || wr_req) begin
                    err_d = 1'b1;
                end
            end
            S_REQ: begin
                mem_stall = 1'b1;
                mem_en    = 1'b1;
                if (!mem_busy) begin
                    tmr_clr = 1'b1;
                    if (mem_done) begin
                        ok_d    = 1'b1;
                        state_d = S_DONE;
                        if (!wr_q) rdata_d = mem_rdata;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                tmr_en    = 1'b1;
                // A completion on the last allowed cycle wins over the timeout.
                if (mem_done) begin
                    ok_d    = 1'b1;
                    state_d = S_DONE;
                    if (!wr_q) rdata_d = mem_rdata;
                end else if (tmr_tc) begin
                    ok_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                    if (!wr_q) rdata_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            wr_q        <= 1'b0;
            ok_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            wr_q        <= wr_d;
            ok_q        <= ok_d;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == S_DONE) && ok_q && !wr_q;
    assign err         = err_q;
    assign mem_wr      = mem_en && wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb/tb_mem_stall_ctrl.sv - directed and randomized checks of mem_stall_ctrl against a behavioural model
module tb_mem_stall_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req = 1'b0, wr_req = 1'b0, mem_busy = 1'b0, mem_done = 1'b0;
    logic [15:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic        mem_stall, rdata_valid, err, mem_en, mem_wr;
    logic [15:0] rdata, mem_addr, mem_wdata;

    mem_stall_ctrl #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .addr        (addr),
        .wdata       (wdata),
        .mem_stall   (mem_stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_busy    (mem_busy),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        m_err   = 1'b0;
    logic [15:0] m_rdata = '0;

    int o_first_en, o_done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Acts as pipeline (holds the request until the stall drops) and as memory.
    // d = cycles after the accepting REQ cycle at which mem_done arrives (0 = same cycle).
    task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input int busy_n, input int d, input logic [15:0] rv);
        int   busy_left, k, o_stall, o_en, o_rv, waits, exp_stall, exp_en, exp_rv;
        bit   accepted, last, o_bad;
        logic valid, tout;
        busy_left = busy_n; k = 0; accepted = 0; last = 0; o_bad = 0;
        o_stall = 0; o_en = 0; o_rv = 0; o_first_en = -1; o_done_cyc = -1;
        rd_req = rd; wr_req = wr; addr = a; wdata = wd; mem_rdata = rv;
        for (int c = 0; c < 40 && !last; c++) begin
            @(negedge clk);
            if (mem_stall) o_stall++;
            if (rdata_valid) o_rv++;
            if (mem_en) begin
                o_en++;
                if (o_first_en < 0) o_first_en = cyc;
                if (mem_wr !== wr || mem_addr !== a) o_bad = 1;
                if (wr && mem_wdata !== wd) o_bad = 1;
            end
            mem_busy = 1'b0;
            mem_done = 1'b0;
            if (accepted) begin
                k++;
                mem_done = (k == d);
            end else if (mem_en) begin
                if (busy_left > 0) begin
                    mem_busy = 1'b1;
                    busy_left--;
                end else begin
                    accepted = 1;
                    mem_done = (d == 0);
                end
            end
            if (!mem_stall) begin
                last = 1;
                o_done_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        rd_req = 1'b0; wr_req = 1'b0; mem_busy = 1'b0; mem_done = 1'b0;

        valid = (rd ^ wr) && !a[0];
        if (!valid) begin
            if (rd || wr) m_err = 1'b1;
            exp_stall = 0; exp_en = 0; exp_rv = 0;
        end else begin
            tout      = (d > TMO);
            waits     = (d == 0) ? 0 : (tout ? TMO : d);
            exp_en    = busy_n + 1;
            exp_stall = 2 + busy_n + waits;
            if (tout) m_err = 1'b1;
            if (rd) m_rdata = tout ? 16'h0 : rv;
            exp_rv = (rd && !tout) ? 1 : 0;
        end
        chk("finished",    32'(last), 32'd1);
        chk("stall_cycles", o_stall,  exp_stall);
        chk("mem_en_cycles", o_en,    exp_en);
        chk("mem_fields",  32'(o_bad), 32'd0);
        chk("rdata_valid_pulses", o_rv, exp_rv);
        chk("rdata",       32'(rdata), 32'(m_rdata));
        chk("err",         32'(err),   32'(m_err));
    endtask

    initial begin
        int first_done;
        #2;
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_outs", {26'd0, rdata_valid, err, mem_en, mem_wr, 2'b00}, 0);
        chk("rst_regs", {rdata, mem_addr}, 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        access(1, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF);
        access(0, 1, 16'h0020, 16'h1234, 2, 1, 16'h0000);
        chk("store_keeps_rdata", 32'(rdata), 32'h0000BEEF);

        access(1, 0, 16'h0030, 16'h0000, 0, 2, 16'h1111);
        first_done = o_done_cyc;
        access(1, 0, 16'h0032, 16'h0000, 0, 0, 16'h2222);
        chk("b2b_gap", o_first_en - first_done, 2);

        access(1, 0, 16'h0040, 16'h0000, 1, 99, 16'h7777);

        // Reset in the middle of a WAIT, then a late mem_done.
        rst = 1'b0; #1; rst = 1'b1;
        m_err = 1'b0; m_rdata = '0;
        rd_req = 1'b1; addr = 16'h0044;
        repeat (4) @(negedge clk);
        rd_req = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("midrst_outs", {27'd0, mem_stall, rdata_valid, err, mem_en, mem_wr}, 0);
        chk("midrst_rdata", 32'(rdata), 0);
        mem_done = 1'b1; mem_rdata = 16'hDEAD;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("late_done_ignored", {29'd0, mem_stall, mem_en, rdata_valid}, 0);
        @(posedge clk); #1 mem_done = 1'b0;
        chk("late_done_rdata", 32'(rdata), 0);
        access(1, 0, 16'h0050, 16'h0000, 0, 3, 16'h5A5A);

        access(1, 0, 16'h0011, 16'h0000, 0, 1, 16'hAAAA);
        access(1, 1, 16'h0060, 16'h0000, 0, 1, 16'hAAAA);

        for (int i = 0; i < 24; i++) begin
            int          sel, gap;
            logic        r, w;
            logic [15:0] a;
            sel = int'($urandom_range(0, 9));
            r   = (sel < 5) || (sel == 9);
            w   = (sel >= 5);
            a   = 16'($urandom) & 16'hFFFE;
            if (sel == 4) a[0] = 1'b1;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("idle_no_stall", {30'd0, mem_stall, mem_en}, 0);
                @(posedge clk); #1;
            end
            access(r, w, a, 16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                   16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
